// File: rtl/soc_cpu_oci_dct_pkg.sv
// OCI DCT trace buffer shared definitions.
// Frame geometry and controller state encoding.
package soc_cpu_oci_dct_pkg;

   localparam int FRAME_W = 2;
   localparam int FRAMES  = 15;
   localparam int CNT_W   = 4;
   localparam int BUF_W   = FRAME_W * FRAMES;

   typedef enum logic [1:0] {
      RUN,
      ENDING,
      ENDED
   } dct_state_t;

endpackage

// File: rtl/soc_cpu_oci_dct_packer.sv
// OCI DCT frame accumulator.
// Inserts accepted frames at the next free slot and counts them.
module soc_cpu_oci_dct_packer #(
   parameter int FRAME_W = 2,
   parameter int FRAMES  = 15,
   parameter int CNT_W   = 4,
   parameter int BUF_W   = FRAME_W * FRAMES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               accept,
   input  logic [FRAME_W-1:0] frame,
   input  logic               clear,
   output logic [CNT_W-1:0]   acc_cnt,
   output logic [BUF_W-1:0]   new_acc,
   output logic [CNT_W-1:0]   new_cnt
);

   logic [BUF_W-1:0] acc;
   logic [BUF_W-1:0] ins;

   // Next accumulator contents including a same-cycle frame.
   always_comb begin
      ins = '0;
      if (accept)
         ins = {{(BUF_W-FRAME_W){1'b0}}, frame}
               << (FRAME_W * int'(acc_cnt));
      new_acc = acc | ins;
      new_cnt = acc_cnt + CNT_W'(accept);
   end

   // Accumulator register; cleared when its word is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (clear) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else begin
         acc     <= new_acc;
         acc_cnt <= new_cnt;
      end
   end

endmodule

// File: rtl/soc_cpu_oci_dct_controller.sv
// OCI DCT buffer controller.
// Packs trace frames into words and runs the test-end drain.
module soc_cpu_oci_dct_controller
   import soc_cpu_oci_dct_pkg::*;
#(
   parameter int FRAME_W = soc_cpu_oci_dct_pkg::FRAME_W,
   parameter int FRAMES  = soc_cpu_oci_dct_pkg::FRAMES,
   parameter int CNT_W   = soc_cpu_oci_dct_pkg::CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       trace_valid,
   input  logic [FRAME_W-1:0]         trace_frame,
   output logic                       trace_ready,
   input  logic                       flush_req,
   input  logic                       test_end_req,
   output logic [FRAME_W*FRAMES-1:0]  dct_buffer,
   output logic [CNT_W-1:0]           dct_count,
   output logic                       dct_valid,
   input  logic                       dct_ready,
   output logic                       test_ending,
   output logic                       test_has_ended
);

   localparam int BW = FRAME_W * FRAMES;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAMES);

   dct_state_t state, state_nx;

   logic             alive;
   logic             flush_pending;
   logic             accept;
   logic             flushing;
   logic             emit;
   logic             slot_free;
   logic             load;
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] new_cnt;
   logic [BW-1:0]    new_acc;

   assign trace_ready = alive && (state == RUN) && (acc_cnt < FULL);
   assign accept      = trace_valid && trace_ready;

   soc_cpu_oci_dct_packer #(
      .FRAME_W (FRAME_W),
      .FRAMES  (FRAMES),
      .CNT_W   (CNT_W),
      .BUF_W   (BW)
   ) u_packer (
      .clk     (clk),
      .reset   (reset),
      .accept  (accept),
      .frame   (trace_frame),
      .clear   (load),
      .acc_cnt (acc_cnt),
      .new_acc (new_acc),
      .new_cnt (new_cnt)
   );

   // Emit decision and next drain state.
   always_comb begin
      flushing  = flush_pending || flush_req || (state == ENDING);
      emit      = (new_cnt == FULL) || (flushing && (new_cnt != '0));
      slot_free = !dct_valid || dct_ready;
      load      = emit && slot_free;
      state_nx  = state;
      unique case (state)
         RUN:
            if (test_end_req)
               state_nx = ENDING;
         ENDING:
            if ((acc_cnt == '0) && slot_free)
               state_nx = ENDED;
         default:
            state_nx = ENDED;
      endcase
   end

   assign test_ending    = (state != RUN);
   assign test_has_ended = (state == ENDED);

   // State, flush bookkeeping and the output word register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RUN;
         alive         <= 1'b0;
         flush_pending <= 1'b0;
         dct_buffer    <= '0;
         dct_count     <= '0;
         dct_valid     <= 1'b0;
      end else begin
         state <= state_nx;
         alive <= 1'b1;
         if (load) begin
            dct_buffer    <= new_acc;
            dct_count     <= new_cnt;
            dct_valid     <= 1'b1;
            flush_pending <= 1'b0;
         end else begin
            if (dct_valid && dct_ready)
               dct_valid <= 1'b0;
            if (flush_req && (new_cnt != '0))
               flush_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_soc_cpu_oci_dct_controller.sv
// Self-checking bench for the OCI DCT buffer controller.
// Directed cases plus random traffic against a frame-queue model.
module tb_soc_cpu_oci_dct_controller;

   logic        clk;
   logic        reset;
   logic        trace_valid;
   logic [1:0]  trace_frame;
   logic        trace_ready;
   logic        flush_req;
   logic        test_end_req;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid;
   logic        dct_ready;
   logic        test_ending;
   logic        test_has_ended;

   int n_chk = 0;
   int n_err = 0;

   // Model: frames waiting in the accumulator, plus the output word.
   int          mq[$];
   bit          m_ov;
   logic [29:0] m_ob;
   int          m_oc;
   bit          m_pend;
   int          m_st;
   bit          m_alive;

   soc_cpu_oci_dct_controller dut (
      .clk            (clk),
      .reset          (reset),
      .trace_valid    (trace_valid),
      .trace_frame    (trace_frame),
      .trace_ready    (trace_ready),
      .flush_req      (flush_req),
      .test_end_req   (test_end_req),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .dct_valid      (dct_valid),
      .dct_ready      (dct_ready),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [29:0] pack(int q[$]);
      logic [29:0] w;
      w = '0;
      foreach (q[i])
         w = w | (30'(q[i]) << (2 * i));
      return w;
   endfunction

   function automatic bit m_rdy();
      return m_alive && (m_st == 0) && (mq.size() < 15);
   endfunction

   task automatic check_all();
      chk("trace_ready", 32'(trace_ready), 32'(m_rdy()));
      chk("dct_valid", 32'(dct_valid), 32'(m_ov));
      chk("dct_count", 32'(dct_count), 32'(m_oc));
      chk("dct_buffer", 32'(dct_buffer), 32'(m_ob));
      chk("test_ending", 32'(test_ending), 32'(m_st != 0));
      chk("test_has_ended", 32'(test_has_ended),
          32'(m_st == 2));
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_step();
      int  n;
      bit  emit;
      bit  free;
      int  st_nx;
      if (trace_valid && m_rdy())
         mq.push_back(int'(trace_frame));
      n     = mq.size();
      emit  = (n == 15) ||
              ((m_pend || flush_req || m_st == 1) && n > 0);
      free  = !m_ov || dct_ready;
      st_nx = m_st;
      if (m_st == 0 && test_end_req)
         st_nx = 1;
      else if (m_st == 1 && n == 0 && free)
         st_nx = 2;
      if (emit && free) begin
         m_ob   = pack(mq);
         m_oc   = n;
         m_ov   = 1'b1;
         m_pend = 1'b0;
         mq.delete();
      end else begin
         if (m_ov && dct_ready)
            m_ov = 1'b0;
         if (flush_req && n > 0)
            m_pend = 1'b1;
      end
      m_st    = st_nx;
      m_alive = 1'b1;
   endtask

   task automatic cyc(bit tv, logic [1:0] tf, bit fr,
                      bit te, bit dr);
      check_all();
      trace_valid  = tv;
      trace_frame  = tf;
      flush_req    = fr;
      test_end_req = te;
      dct_ready    = dr;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(bit dr);
      cyc(1'b0, 2'd0, 1'b0, 1'b0, dr);
   endtask

   task automatic do_reset();
      trace_valid  = 1'b0;
      trace_frame  = 2'd0;
      flush_req    = 1'b0;
      test_end_req = 1'b0;
      dct_ready    = 1'b0;
      reset        = 1'b1;
      mq.delete();
      m_ov    = 1'b0;
      m_ob    = '0;
      m_oc    = 0;
      m_pend  = 1'b0;
      m_st    = 0;
      m_alive = 1'b0;
      #1;
      chk("rst_valid", 32'(dct_valid), 32'd0);
      chk("rst_count", 32'(dct_count), 32'd0);
      chk("rst_buffer", 32'(dct_buffer), 32'd0);
      chk("rst_ready", 32'(trace_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      idle(1'b1);
      chk("ready_after_rst", 32'(trace_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      do_reset();

      for (int i = 0; i < 15; i++)
         cyc(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      chk("full_valid", 32'(dct_valid), 32'd1);
      chk("full_buf", 32'(dct_buffer), 32'h24E4E4E4);
      chk("full_cnt", 32'(dct_count), 32'd15);
      idle(1'b1);

      for (int i = 0; i < 3; i++)
         cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      chk("flush3_buf", 32'(dct_buffer), 32'h3F);
      chk("flush3_cnt", 32'(dct_count), 32'd3);
      idle(1'b1);

      for (int i = 0; i < 3; i++)
         cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
      chk("flush4_cnt", 32'(dct_count), 32'd4);
      idle(1'b1);

      cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      chk("flush_empty", 32'(dct_valid), 32'd0);
      idle(1'b1);

      for (int i = 0; i < 30; i++)
         cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("bp_buf", 32'(dct_buffer), 32'h15555555);
      chk("bp_cnt", 32'(dct_count), 32'd15);
      chk("bp_ready_low", 32'(trace_ready), 32'd0);
      idle(1'b1);
      chk("bp_word2_valid", 32'(dct_valid), 32'd1);
      chk("bp_word2_buf", 32'(dct_buffer), 32'h15555555);
      chk("bp_ready_back", 32'(trace_ready), 32'd1);
      idle(1'b1);

      for (int i = 0; i < 15; i++)
         cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      chk("pend_hold_cnt", 32'(dct_count), 32'd15);
      idle(1'b0);
      idle(1'b1);
      chk("pend_emit_cnt", 32'(dct_count), 32'd2);
      chk("pend_emit_buf", 32'(dct_buffer), 32'hF);
      idle(1'b1);

      for (int i = 0; i < 22; i++)
         cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 15; i++)
         cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
      chk("fresh_cnt", 32'(dct_count), 32'd15);
      chk("fresh_buf", 32'(dct_buffer), 32'h3FFFFFFF);
      idle(1'b1);

      for (int i = 0; i < 600; i++)
         cyc(($urandom % 4) != 0, 2'($urandom),
             ($urandom % 16) == 0, 1'b0,
             ($urandom % 3) != 0);
      cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
      repeat (3) idle(1'b1);

      for (int i = 0; i < 4; i++)
         cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
      chk("end_ending", 32'(test_ending), 32'd1);
      chk("end_not_ended", 32'(test_has_ended), 32'd0);
      cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      chk("end_word_buf", 32'(dct_buffer), 32'h2AA);
      chk("end_word_cnt", 32'(dct_count), 32'd5);
      cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      chk("end_ended", 32'(test_has_ended), 32'd1);
      chk("end_ready", 32'(trace_ready), 32'd0);
      repeat (4) cyc(1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
      chk("end_sticky", 32'(test_has_ended), 32'd1);

      do_reset();
      for (int i = 0; i < 400; i++)
         cyc(($urandom % 3) != 0, 2'($urandom),
             ($urandom % 12) == 0,
             (i > 300) && (($urandom % 40) == 0),
             ($urandom % 2) != 0);
      cyc(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      repeat (6) idle(1'b1);
      chk("rand_ended", 32'(test_has_ended), 32'd1);
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
